// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// State encoding and its width.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first.
// One full-adder cell plus a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = (state_q == S_RUN);
    done_d  = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // carry_q here is the carry into the MSB
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = acc_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 2 and 16.
// Assertion-checked against hand-derived values.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;
  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .overflow(ovf2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16),
    .cout(cout16), .overflow(ovf16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic ic, output int lat, output int bsy);
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; bsy = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bsy++;
    end
  endtask

  task automatic go2(input logic [1:0] ia, input logic [1:0] ib,
                     input logic ic, output int lat);
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic go16(input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, output int lat);
    @(negedge clk);
    a16 = ia; b16 = ib; cin16 = ic; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bsy, cyc, last, idx, dcnt;
    logic [7:0] va[4], vb[4], es[4];
    logic       vc[4], ec[4], eo[4];
    logic [2:0]  t2;
    logic        o2;
    logic [15:0] ra, rb;
    logic        rc, o16;
    logic [16:0] t16;

    va = '{8'h12, 8'h80, 8'hC8, 8'h7F};
    vb = '{8'h34, 8'h80, 8'h64, 8'h7F};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{8'h46, 8'h00, 8'h2D, 8'hFF};
    ec = '{1'b0, 1'b1, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy8, 1'b0);
    chk("rst done", done8, 1'b0);
    chk("rst sum", sum8, 8'h00);
    chk("rst cout", cout8, 1'b0);
    chk("rst ovf", ovf8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    go8(8'h00, 8'h00, 1'b0, lat, bsy);
    chk("zero latency", lat, 9);
    chk("zero busy cycles", bsy, 8);
    chk("zero sum", sum8, 8'h00);
    chk("zero cout", cout8, 1'b0);
    chk("zero ovf", ovf8, 1'b0);

    go8(8'hFF, 8'h01, 1'b0, lat, bsy);
    chk("ff+01 latency", lat, 9);
    chk("ff+01 sum", sum8, 8'h00);
    chk("ff+01 cout", cout8, 1'b1);
    chk("ff+01 ovf", ovf8, 1'b0);

    go8(8'h7F, 8'h01, 1'b0, lat, bsy);
    chk("7f+01 sum", sum8, 8'h80);
    chk("7f+01 cout", cout8, 1'b0);
    chk("7f+01 ovf", ovf8, 1'b1);

    // restart attempts while running must be ignored
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("mid busy", busy8, 1'b1);
    a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
    lat = 1;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    chk("mid sum held", sum8, 8'h80);
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mid latency", lat, 9);
    chk("mid sum", sum8, 8'hFF);
    chk("mid cout", cout8, 1'b1);
    chk("mid ovf", ovf8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid no restart", busy8, 1'b0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst busy", busy8, 1'b0);
    chk("arst done", done8, 1'b0);
    chk("arst sum", sum8, 8'h00);
    chk("arst cout", cout8, 1'b0);
    chk("arst ovf", ovf8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcnt++;
    end
    chk("arst no done", dcnt, 0);
    go8(8'h10, 8'h20, 1'b0, lat, bsy);
    chk("post-rst latency", lat, 9);
    chk("post-rst sum", sum8, 8'h30);
    chk("post-rst cout", cout8, 1'b0);

    // start held high: back-to-back operation
    @(negedge clk);
    a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; start8 = 1'b1;
    cyc = 0; last = 0; idx = 0;
    while (idx < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        chk("b2b sum", sum8, es[idx]);
        chk("b2b cout", cout8, ec[idx]);
        chk("b2b ovf", ovf8, eo[idx]);
        if (idx > 0) chk("b2b period", cyc - last, 10);
        last = cyc;
        idx++;
        if (idx < 4) begin
          a8 = va[idx]; b8 = vb[idx]; cin8 = vc[idx];
        end
      end
    end
    start8 = 1'b0;
    chk("b2b count", idx, 4);

    // WIDTH=2 exhaustive
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int c = 0; c < 2; c++) begin
          t2 = 3'(i) + 3'(j) + 3'(c);
          o2 = (i[1] == j[1]) && (t2[1] != i[1]);
          go2(i[1:0], j[1:0], c[0], lat);
          chk("w2 latency", lat, 3);
          chk("w2 sum", sum2, t2[1:0]);
          chk("w2 cout", cout2, t2[2]);
          chk("w2 ovf", ovf2, o2);
        end
      end
    end

    // WIDTH=16 random
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      t16 = 17'(ra) + 17'(rb) + 17'(rc);
      o16 = (ra[15] == rb[15]) && (t16[15] != ra[15]);
      go16(ra, rb, rc, lat);
      chk("w16 latency", lat, 17);
      chk("w16 sum", sum16, t16[15:0]);
      chk("w16 cout", cout16, t16[16]);
      chk("w16 ovf", ovf16, o16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder. Computes WIDTH-bit A + B + Cin one bit per clock, LSB first, using a single full-adder cell and a registered carry. Uses a start/busy/done handshake and holds the result until the next accepted start. Next-generation arithmetic block for area-constrained datapaths where one full-adder cell per bit is too costly.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; asynchronous, active-low.
start  input  1  request; sampled on rising clk while idle.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in; captured on accepted start.
busy  output  1  high while bits are being computed.
done  output  1  single-cycle pulse; result valid.
sum  output  WIDTH  result; stable from done until next accepted start.
cout  output  1  carry out of MSB.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, state=IDLE, counter=0, carry register=0, operand shift registers=0.
- States:
  - IDLE: start=1 captures a, b and cin into the shift registers and carry register. It clears the counter and goes to RUN.
  - RUN: each edge adds the LSBs of the A and B shift registers plus the carry register in the full-adder cell, shifts the sum bit into the MSB of the sum shift register, shifts A and B right, registers the new carry and increments the counter. After WIDTH edges in RUN, the state goes to DONE.
  - DONE: lasts one cycle, then the state goes to IDLE.
- Outputs by state: busy=1 only in RUN; done=1 only in DONE.
- Final bit: on the last RUN edge, cout takes the final carry. overflow takes the carry into the MSB XOR the final carry; the carry into the MSB is the carry register value before the last edge.
- Latency: start sampled at edge k gives busy high after edges k+1..k+WIDTH and done high after edge k+WIDTH+1. Total WIDTH+1 cycles from start to done.
- Boundary conditions:
  - start while in RUN or DONE: ignored. Captured operands and the result are unaffected.
  - start in the cycle right after done (IDLE): accepted, giving back-to-back operation with a throughput of WIDTH+2 cycles.
  - a, b or cin changing while busy: no effect.
  - rst_n low mid-operation: all registers return to reset values immediately and asynchronously. The partial result is discarded, done does not pulse, and the block waits for a new start after release.
  - sum, cout and overflow: not updated bit-by-bit where externally visible. Internal shifting uses a separate register, and sum is loaded whole on entry to DONE; it holds its previous value while busy.
  - Arithmetic: the result is exactly (a + b + cin) mod 2^WIDTH, and cout is bit WIDTH of the full sum.

Decomposition:
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE) and the 2-bit state width constant.
- Sub-module: one instance of the existing full_adder cell (a, b, cin, sum, cout) for the per-bit add. Everything else is flat in serial_adder.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, overflow=0; done exactly 9 cycles after start edge; busy high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
- WIDTH=8, a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0. Second start held high 3 cycles mid-RUN with a=0x01 -> ignored; result unchanged.
- WIDTH=8, start a=0x55, b=0x0F; assert rst_n=0 after 4 busy cycles -> all outputs 0 immediately, no done. After release, start a=0x10, b=0x20 -> sum=0x30.
- WIDTH=8, start held high continuously with new operands each done -> back-to-back results every 10 cycles, each matching the reference model.
- WIDTH=2 and WIDTH=16: exhaustive (WIDTH=2) / 1000 random (WIDTH=16) a, b, cin -> sum, cout and overflow match the golden {cout,sum}=a+b+cin.
